// File: rtl/mwadd_pkg.sv
// Shared types and helpers for the multi-word sequential adder.
package mwadd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mwadd_state_t;

    // Chunk counter width; never narrower than one bit.
    function automatic int cnt_width(input int words);
        return (words > 2) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/adder.sv
// N-bit ripple-carry adder used as the per-chunk arithmetic stage.
module adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < N; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[N];
    end

endmodule

// File: rtl/mwadd_seq.sv
// Multi-word sequential adder: streams WORDS chunks of N bits through one ripple adder.
// Optional signed-overflow output out_ovf is enabled by defining MWADD_OVF_EN.
module mwadd_seq
    import mwadd_pkg::*;
#(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] in_a,
    input  logic [N*WORDS-1:0] in_b,
    input  logic               in_cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] out_sum,
    output logic               out_cout,
`ifdef MWADD_OVF_EN
    output logic               out_ovf,
`endif
    output logic               busy
);

    localparam int W  = N * WORDS;
    localparam int CW = cnt_width(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    mwadd_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          rdy_q, rdy_d;
    logic          accept;

    logic [N-1:0]  add_a, add_b, add_sum;
    logic          add_cout;

    assign accept = (state_q == IDLE) && in_valid && rdy_q;

    assign add_a = a_q[int'(cnt_q)*N +: N];
    assign add_b = b_q[int'(cnt_q)*N +: N];

    adder #(.N(N)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // in_ready is registered so it stays low throughout reset and rises one edge later.
    assign in_ready = rdy_q;
    assign out_sum  = sum_q;
    assign out_cout = carry_q;

`ifdef MWADD_OVF_EN
    logic ovf_q, ovf_d;
    assign out_ovf = ovf_q;
`endif

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        rdy_d   = (state_d == IDLE);
`ifdef MWADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (accept) begin
            a_d     = in_a;
            b_d     = in_b;
            carry_d = in_cin;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            sum_d[int'(cnt_q)*N +: N] = add_sum;
            carry_d                   = add_cout;
            if (cnt_q != LAST) cnt_d = cnt_q + 1'b1;
`ifdef MWADD_OVF_EN
            // Carry into the MSB is recovered as a^b^sum at that bit.
            if (cnt_q == LAST)
                ovf_d = (add_a[N-1] ^ add_b[N-1] ^ add_sum[N-1]) ^ add_cout;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
`ifdef MWADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
`ifdef MWADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_mwadd_seq.sv
// Self-checking bench for mwadd_seq: vector table, hand sequences, randomized ops vs arithmetic model.
module tb_mwadd_seq;

    localparam int N     = 4;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;
    logic         ovf_obs;
`ifdef MWADD_OVF_EN
    logic         out_ovf;
    assign ovf_obs = out_ovf;
`else
    assign ovf_obs = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [W+1:0] exp_q[$];

    mwadd_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
`ifdef MWADD_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .busy      (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // {ovf, cout, sum} from plain wide arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] s;
        logic       ovf;
        s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {ovf, s[W], s[W-1:0]};
    endfunction

    // Carry out of the low (k+1) chunks.
    function automatic logic chunk_carry(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int k);
        logic [31:0] mask;
        logic [31:0] s;
        mask = (32'd1 << ((k + 1) * N)) - 32'd1;
        s    = (32'(a) & mask) + (32'(b) & mask) + 32'(cin);
        return s[(k + 1) * N];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("in_ready_before_op", 32'(in_ready), 32'd1);
    endtask

    task automatic wait_out_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_hs", 32'(out_valid), 32'd0);
        check("in_ready_after_hs", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int hold,
                          output logic [W-1:0] r_sum, output logic r_cout, output logic r_ovf);
        int lat;
        logic [W+1:0] e;
        logic [W-1:0] held;
        wait_ready();
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        exp_q.push_back(model(a, b, cin));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_cin   = 1'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
        wait_out_valid(lat);
        check("latency", 32'(lat), 32'(WORDS));
        held = out_sum;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            in_a     = W'($urandom);
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(out_sum), 32'(held));
        end
        in_valid = 1'b0;
        e = exp_q.pop_front();
        check("sum", 32'(out_sum), 32'(e[W-1:0]));
        check("cout", 32'(out_cout), 32'(e[W]));
`ifdef MWADD_OVF_EN
        check("ovf", 32'(ovf_obs), 32'(e[W+1]));
`endif
        r_sum  = out_sum;
        r_cout = out_cout;
        r_ovf  = ovf_obs;
        handshake_out();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [W-1:0] r_sum;
        logic         r_cout, r_ovf;
        int           lat;
        logic [W-1:0] held;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1};
        vecs[6] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};

        // ---------------- reset ----------------
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_cout", 32'(out_cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef MWADD_OVF_EN
        check("rst_out_ovf", 32'(ovf_obs), 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        check("in_ready_before_first_edge", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("in_ready_after_release", 32'(in_ready), 32'd1);

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, r_sum, r_cout, r_ovf);
            check($sformatf("vec%0d_sum", i), 32'(r_sum), 32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(r_cout), 32'(vecs[i].cout));
`ifdef MWADD_OVF_EN
            check($sformatf("vec%0d_ovf", i), 32'(r_ovf), 32'(vecs[i].ovf));
`endif
        end

        // ---------------- full carry chain, per-chunk carry ----------------
        begin
            logic [W-1:0] ca, cb;
            logic         cc;
            ca = 16'hFFFF; cb = 16'h0000; cc = 1'b1;
            wait_ready();
            in_valid = 1'b1; in_a = ca; in_b = cb; in_cin = cc;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("chain_carry_load", 32'(dut.carry_q), 32'(cc));
            for (int k = 0; k < WORDS; k++) begin
                @(posedge clk); #1;
                check($sformatf("chain_carry_chunk%0d", k), 32'(dut.carry_q), 32'(chunk_carry(ca, cb, cc, k)));
            end
            check("chain_out_valid", 32'(out_valid), 32'd1);
            check("chain_sum", 32'(out_sum), 32'h0000);
            check("chain_cout", 32'(out_cout), 32'd1);
            handshake_out();

            // Mixed pattern where the carry toggles between chunks.
            ca = 16'h08F7; cb = 16'h0809; cc = 1'b0;
            wait_ready();
            in_valid = 1'b1; in_a = ca; in_b = cb; in_cin = cc;
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int k = 0; k < WORDS; k++) begin
                @(posedge clk); #1;
                check($sformatf("mix_carry_chunk%0d", k), 32'(dut.carry_q), 32'(chunk_carry(ca, cb, cc, k)));
            end
            check("mix_sum", 32'(out_sum), 32'h1100);
            handshake_out();
        end

        // ---------------- backpressure ----------------
        wait_ready();
        in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out_valid(lat);
        check("bp_latency", 32'(lat), 32'(WORDS));
        held = out_sum;
        check("bp_sum", 32'(held), 32'h3333);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            @(posedge clk); #1;
            check("bp_valid_held", 32'(out_valid), 32'd1);
            check("bp_sum_held", 32'(out_sum), 32'h3333);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        in_a = 16'h0F0F; in_b = 16'h0101; in_cin = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_accepted", 32'(busy), 32'd1);
        check("bp_next_in_ready", 32'(in_ready), 32'd0);
        wait_out_valid(lat);
        check("bp_next_latency", 32'(lat), 32'(WORDS));
        check("bp_next_sum", 32'(out_sum), 32'h1010);
        handshake_out();

        // ---------------- reset mid-RUN ----------------
        wait_ready();
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0FFF; in_cin = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_sum", 32'(out_sum), 32'd0);
        check("midrst_out_cout", 32'(out_cout), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst_no_valid", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("postrst_no_valid", 32'(out_valid), 32'd0);
        end
        run_op(16'h1234, 16'h1111, 1'b0, 0, r_sum, r_cout, r_ovf);
        check("postrst_sum", 32'(r_sum), 32'h2345);

        // ---------------- randomized ----------------
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   r_sum, r_cout, r_ovf);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
